// File: rtl/arm_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : arm_mc_controller
// Brief    : Multicycle ARM-subset control FSM with memory wait/timeout handling.
// Revision : 1.0
// ============================================================================
module arm_mc_controller #(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [19:0]           Instr,
  input  logic [3:0]            ALUFlags,
  input  logic                  MemReady,
  output logic                  PCWrite,
  output logic                  IRWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic                  ALUSrcA,
  output logic                  MemByte,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  MemErr,
  output logic                  Halted
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

  state_t     r_state, w_next;
  logic [7:0] r_cnt;
  logic [3:0] r_flags;
  logic       r_memerr;

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_cmd;
  logic       w_cond_ok;
  logic       w_cond_raw;
  logic [1:0] w_alu_op;
  logic [1:0] w_alu_sel;
  logic       w_dp_wr;
  logic       w_logical;
  logic       w_wait_state;
  logic       w_timeout;
  logic       w_unused;

  assign w_cond   = Instr[19:16];
  assign w_op     = Instr[15:14];
  assign w_funct  = Instr[13:8];
  assign w_cmd    = w_funct[4:1];
  assign w_unused = ^Instr[7:0];

  // Flags are held as {N,Z,C,V}
  always_comb begin
    w_cond_raw = 1'b0;
    case (w_cond)
      4'b0000: w_cond_raw = r_flags[2];
      4'b0001: w_cond_raw = ~r_flags[2];
      4'b0010: w_cond_raw = r_flags[1];
      4'b0011: w_cond_raw = ~r_flags[1];
      4'b0100: w_cond_raw = r_flags[3];
      4'b0101: w_cond_raw = ~r_flags[3];
      4'b0110: w_cond_raw = r_flags[0];
      4'b0111: w_cond_raw = ~r_flags[0];
      4'b1000: w_cond_raw = r_flags[1] & ~r_flags[2];
      4'b1001: w_cond_raw = ~r_flags[1] | r_flags[2];
      4'b1010: w_cond_raw = (r_flags[3] == r_flags[0]);
      4'b1011: w_cond_raw = (r_flags[3] != r_flags[0]);
      4'b1100: w_cond_raw = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'b1101: w_cond_raw = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'b1110: w_cond_raw = 1'b1;
      default: w_cond_raw = 1'b0;
    endcase
  end

  assign w_cond_ok = w_cond_raw & (w_op != 2'b11);

  always_comb begin
    w_alu_op  = 2'd0;
    w_dp_wr   = 1'b0;
    w_logical = 1'b0;
    case (w_cmd)
      4'b0100: begin w_alu_op = 2'd0; w_dp_wr = 1'b1; end
      4'b0010: begin w_alu_op = 2'd1; w_dp_wr = 1'b1; end
      4'b0000: begin w_alu_op = 2'd2; w_dp_wr = 1'b1; w_logical = 1'b1; end
      4'b1100: begin w_alu_op = 2'd3; w_dp_wr = 1'b1; w_logical = 1'b1; end
      4'b1010: begin w_alu_op = 2'd1; w_dp_wr = 1'b0; end
      default: begin w_alu_op = 2'd0; w_dp_wr = 1'b0; end
    endcase
  end

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // A ready arriving on the limit cycle still wins over the timeout
  assign w_timeout    = w_wait_state && !MemReady && (r_cnt == c_timeout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_cnt    <= 8'd0;
      r_flags  <= 4'b0000;
      r_memerr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= 8'd0;
      else if (w_wait_state && !MemReady)
        r_cnt <= r_cnt + 8'd1;
      if (w_timeout)
        r_memerr <= 1'b1;
      if (((r_state == S_EXECR) || (r_state == S_EXECI)) && w_funct[0]) begin
        if (w_logical)
          r_flags[3:2] <= ALUFlags[3:2];
        else
          r_flags <= ALUFlags;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    MemByte   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = 2'b00;
    RegSrc    = 2'b00;
    Halted    = 1'b0;
    w_alu_sel = 2'd0;
    case (r_state)
      S_FETCH: begin
        if (w_timeout) begin
          w_next = S_HALT;
        end else if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!w_cond_ok)
          w_next = S_FETCH;
        else begin
          case (w_op)
            2'b01:   w_next = S_MEMADR;
            2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
            2'b10:   w_next = S_BRANCH;
            default: w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
        w_next  = w_funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        MemByte = w_funct[2];
        if (w_timeout)
          w_next = S_HALT;
        else if (MemReady)
          w_next = S_MEMWB;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        MemByte = w_funct[2];
        if (w_timeout) begin
          w_next = S_HALT;
        end else begin
          MemWrite = 1'b1;
          if (MemReady)
            w_next = S_FETCH;
        end
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_EXECR: begin
        w_alu_sel = w_alu_op;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB   = 2'b01;
        w_alu_sel = w_alu_op;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = w_dp_wr;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ImmSrc    = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign ALUControl = {{(ALU_CTRL_W-2){1'b0}}, w_alu_sel};
  assign MemErr     = r_memerr;

endmodule
`default_nettype wire

// File: tb/tb_arm_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_mc_controller
// Brief    : Scoreboard bench: expected per-cycle outputs queued as stimulus is driven.
// Revision : 1.0
// ============================================================================
module tb_arm_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = 20'd0;
  logic [3:0]  ALUFlags = 4'd0;
  logic        MemReady = 1'b0;
  logic        PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA, MemByte;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0]  ALUControl;
  logic        MemErr, Halted;

  int checks = 0;
  int failures = 0;

  string       tagq[$];
  logic [20:0] expq[$];

  arm_mc_controller #(.ALU_CTRL_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .MemByte(MemByte), .ResultSrc(ResultSrc),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .MemErr(MemErr), .Halted(Halted)
  );

  always #5 clk = ~clk;

  logic [20:0] w_obs;
  assign w_obs = {PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA, MemByte,
                  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, MemErr, Halted};

  task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() != 0) check(tagq.pop_front(), w_obs, expq.pop_front());
  end

  // Expected output vector in the same order as w_obs
  function automatic logic [20:0] ev(input logic pcw, irw, adr, mw, rw, mb,
                                     input logic [1:0] rs, asb, imm,
                                     input logic [3:0] ac, input logic err, halt);
    return {pcw, irw, adr, mw, rw, 1'b0, mb, rs, asb, imm, 2'b00, ac, err, halt};
  endfunction

  function automatic logic [20:0] f_fetch(input logic r);
    return ev(r, r, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0);
  endfunction
  function automatic logic [20:0] f_dec();
    return ev(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0);
  endfunction
  function automatic logic [20:0] f_madr();
    return ev(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 4'd0, 0, 0);
  endfunction
  function automatic logic [20:0] f_mem(input logic mw, input logic b);
    return ev(0, 0, 1, mw, 0, b, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0);
  endfunction
  function automatic logic [20:0] f_wb();
    return ev(0, 0, 0, 0, 1, 0, 2'd1, 2'd0, 2'd0, 4'd0, 0, 0);
  endfunction
  function automatic logic [20:0] f_exec(input logic i, input logic [3:0] ac);
    return ev(0, 0, 0, 0, 0, 0, 2'd0, {1'b0, i}, 2'd0, ac, 0, 0);
  endfunction
  function automatic logic [20:0] f_aluwb(input logic w);
    return ev(0, 0, 0, 0, w, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0);
  endfunction
  function automatic logic [20:0] f_br();
    return ev(1, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0, 0, 0);
  endfunction
  function automatic logic [20:0] f_halt();
    return ev(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 1, 1);
  endfunction

  function automatic logic [19:0] mki(input logic [3:0] cond, input logic [1:0] op,
                                      input logic [5:0] funct);
    return {cond, op, funct, 8'h21};
  endfunction

  // Queue one cycle's expectation, then advance to just after the next rising edge
  task automatic cyc(input string tag, input logic rdy, input logic [20:0] e);
    MemReady = rdy;
    tagq.push_back(tag);
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_dp(input string tag, input logic [3:0] cond, input logic [5:0] funct,
                        input logic [3:0] flg, input logic pass, input logic [3:0] ac,
                        input logic rw, input int nwait);
    Instr    = mki(cond, 2'b00, funct);
    ALUFlags = flg;
    for (int i = 0; i < nwait; i++) cyc({tag, "_fwait"}, 1'b0, f_fetch(1'b0));
    cyc({tag, "_fetch"}, 1'b1, f_fetch(1'b1));
    cyc({tag, "_dec"}, 1'b1, f_dec());
    if (pass) begin
      cyc({tag, "_exec"}, 1'b1, f_exec(funct[5], ac));
      cyc({tag, "_aluwb"}, 1'b1, f_aluwb(rw));
    end
  endtask

  task automatic run_br(input string tag, input logic [3:0] cond, input logic taken);
    Instr = mki(cond, 2'b10, 6'b000000);
    cyc({tag, "_fetch"}, 1'b1, f_fetch(1'b1));
    cyc({tag, "_dec"}, 1'b1, f_dec());
    if (taken) cyc({tag, "_br"}, 1'b1, f_br());
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc("rst_idle", 1'b0, f_fetch(1'b0));
    cyc("rst_rdy", 1'b1, f_fetch(1'b1));
    reset = 1'b0;

    run_dp("add", 4'hE, 6'b001000, 4'b0000, 1'b1, 4'd0, 1'b1, 0);
    run_dp("subs", 4'hE, 6'b100101, 4'b0110, 1'b1, 4'd1, 1'b1, 0);
    run_br("beq", 4'b0000, 1'b1);
    run_br("bne", 4'b0001, 1'b0);

    Instr = mki(4'hE, 2'b01, 6'b011001);
    cyc("ldr_fetch", 1'b1, f_fetch(1'b1));
    cyc("ldr_dec", 1'b1, f_dec());
    cyc("ldr_madr", 1'b1, f_madr());
    for (int i = 0; i < 3; i++) cyc("ldr_rdwait", 1'b0, f_mem(1'b0, 1'b0));
    cyc("ldr_rd", 1'b1, f_mem(1'b0, 1'b0));
    cyc("ldr_wb", 1'b1, f_wb());

    run_dp("cmp", 4'hE, 6'b010101, 4'b1000, 1'b1, 4'd1, 1'b0, 0);
    run_br("blt", 4'b1011, 1'b1);
    run_br("bge", 4'b1010, 1'b0);

    // Logical S-op must leave C and V from the compare (both 0)
    run_dp("ands", 4'hE, 6'b000001, 4'b0011, 1'b1, 4'd2, 1'b1, 0);
    run_br("bcs", 4'b0010, 1'b0);
    run_br("bvs", 4'b0110, 1'b0);
    run_br("bpl", 4'b0101, 1'b1);

    // Ready lands exactly on the timeout limit: normal fetch, no error
    run_dp("orr", 4'hE, 6'b011000, 4'b1111, 1'b1, 4'd3, 1'b1, 4);
    run_br("beq_nz", 4'b0000, 1'b0);
    run_dp("eor", 4'hE, 6'b100010, 4'b0000, 1'b1, 4'd0, 1'b0, 0);

    Instr = mki(4'hE, 2'b11, 6'b001000);
    cyc("op11_fetch", 1'b1, f_fetch(1'b1));
    cyc("op11_dec", 1'b1, f_dec());
    run_dp("nv", 4'hF, 6'b001000, 4'b0000, 1'b0, 4'd0, 1'b0, 0);

    Instr = mki(4'hE, 2'b01, 6'b000000);
    cyc("str_fetch", 1'b1, f_fetch(1'b1));
    cyc("str_dec", 1'b1, f_dec());
    cyc("str_madr", 1'b1, f_madr());
    cyc("str_wait", 1'b0, f_mem(1'b1, 1'b0));
    cyc("str_wr", 1'b1, f_mem(1'b1, 1'b0));

    cyc("str2_fetch", 1'b1, f_fetch(1'b1));
    cyc("str2_dec", 1'b1, f_dec());
    cyc("str2_madr", 1'b1, f_madr());
    MemReady = 1'b0;
    #1;
    check("str2_mw_before", w_obs, f_mem(1'b1, 1'b0));
    reset = 1'b1;
    #1;
    check("str2_mw_reset", w_obs, f_fetch(1'b0));
    cyc("str2_rst", 1'b0, f_fetch(1'b0));
    reset = 1'b0;

    Instr = mki(4'hE, 2'b01, 6'b000100);
    cyc("strb_fetch", 1'b1, f_fetch(1'b1));
    cyc("strb_dec", 1'b1, f_dec());
    cyc("strb_madr", 1'b1, f_madr());
    for (int i = 0; i < 4; i++) cyc("strb_wait", 1'b0, f_mem(1'b1, 1'b1));
    cyc("strb_tmo", 1'b0, f_mem(1'b0, 1'b1));
    cyc("halt0", 1'b0, f_halt());
    for (int i = 0; i < 2; i++) cyc("halt_rdy", 1'b1, f_halt());
    reset = 1'b1;
    cyc("halt_rst", 1'b0, f_fetch(1'b0));
    reset = 1'b0;

    run_dp("add2", 4'hE, 6'b001000, 4'b0000, 1'b1, 4'd0, 1'b1, 0);

    repeat (2) @(negedge clk);
    check("drain", 21'(expq.size()), 21'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arm_mc_controller.md
ARM_MC_CONTROLLER -- requirements
Module: arm_mc_controller

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 4, ALUControl width (minimum 3).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, maximum wait cycles per memory access (1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Instr  input  20  instruction bits [31:12] from the instruction register.
REQ-006 SHALL have port ALUFlags  input  4  {N,Z,C,V} from the ALU, valid in the execute states.
REQ-007 SHALL have port MemReady  input  1  memory access completes in the cycle it is high.
REQ-008 SHALL have ports PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA, MemByte  output  1 each  datapath enables and selects.
REQ-009 SHALL have ports ResultSrc, ALUSrcB, ImmSrc, RegSrc  output  2 each  datapath selects.
REQ-010 SHALL have port ALUControl  output  ALU_CTRL_W  ALU operation code.
REQ-011 SHALL have ports MemErr  output  1  sticky timeout flag; Halted  output  1  high in HALT.

Function
REQ-012 SHALL decode Op=Instr[27:26] (00 DP, 01 memory, 10 branch), Funct=Instr[25:20], Cond=Instr[31:28]; Op=11 SHALL be treated as failed condition.
REQ-013 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, HALT.
REQ-014 FETCH: AdrSrc=0, IRWrite=PCWrite=MemReady; stays in FETCH while MemReady=0; to DECODE when MemReady=1.
REQ-015 DECODE: evaluates Cond against registered flags (ARM EQ..AL, 1111 = never); fail -> FETCH with no side effects; pass -> MEMADR (Op 01), EXECI (Op 00, Funct[5]=1), EXECR (Op 00, Funct[5]=0), BRANCH (Op 10).
REQ-016 MEMADR: ALUSrcB=01, ImmSrc=01, ALUControl=ADD; to MEMRD if Funct[0]=1 (load), else MEMWR.
REQ-017 MEMRD/MEMWR: AdrSrc=1, MemByte=Funct[2]; MEMWR drives MemWrite=1 until MemReady; MEMRD -> MEMWB, MEMWR -> FETCH when MemReady=1.
REQ-018 MEMWB: ResultSrc=01, RegWrite=1 for one cycle; -> FETCH.
REQ-019 EXECR/EXECI: ALUSrcB=00/01, ImmSrc=00; ALUControl from Funct[4:1]: ADD 0100->0, SUB 0010->1, AND 0000->2, ORR 1100->3, CMP 1010->1, other->0; -> ALUWB.
REQ-020 Flags register SHALL load ALUFlags at end of EXECR/EXECI when Funct[0]=1; ADD/SUB/CMP update N,Z,C,V, logical ops update N,Z only.
REQ-021 ALUWB: RegWrite=1 except for CMP and unsupported cmd (RegWrite=0); -> FETCH.
REQ-022 BRANCH: ImmSrc=10, ALUSrcB=01, ResultSrc=10, PCWrite=1 for one cycle; -> FETCH.
REQ-023 All outputs not listed for a state SHALL be 0; ALUControl SHALL be zero-extended to ALU_CTRL_W.
REQ-024 Wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR and increment each cycle MemReady=0 there.
REQ-025 When counter reaches MEM_TIMEOUT with MemReady=0, SHALL set MemErr, enter HALT, suppress MemWrite/PCWrite/IRWrite that cycle.
REQ-026 MemReady=1 in the same cycle the counter reaches MEM_TIMEOUT SHALL complete the access normally (no error).
REQ-027 HALT SHALL hold all enables at 0, Halted=1, until reset.

Reset
REQ-028 reset SHALL asynchronously force state FETCH, flags 0000, counter 0, MemErr 0; outputs SHALL reflect FETCH decoding during and after reset.
REQ-029 Reset asserted mid-access SHALL abort it; no MemWrite/RegWrite pulse after reset asserts.

Verification
REQ-030 ADD R1,R2,R3 (Cond 1110), MemReady=1 -> FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in cycle 4, ALUControl=0.
REQ-031 LDR, MemReady low 3 cycles in MEMRD -> MEMRD held 4 cycles, MEMWB RegWrite=1 once, MemErr=0.
REQ-032 SUBS giving zero, then BEQ -> Z=1 latched, BRANCH taken with PCWrite=1; BNE instead -> DECODE returns to FETCH, no writes.
REQ-033 STRB, MemReady held 0, MEM_TIMEOUT=4 -> MemErr=1 and Halted=1 after 4 wait cycles, MemWrite=0 thereafter.
REQ-034 CMP R1,R2 -> flags updated, RegWrite never asserted.
REQ-035 reset pulsed during MEMWR -> state FETCH immediately, MemWrite=0, MemErr=0.
